// File: rtl/hazard_stall_unit_pkg.sv
// Shared constants for the hazard/stall unit: RV32I major opcodes, FSM
// state encodings and the register index that ECALL reads its code from.
package hazard_stall_unit_pkg;

  localparam logic [6:0] OP_LOAD           = 7'b0000011;
  localparam logic [6:0] OP_STORE          = 7'b0100011;
  localparam logic [6:0] OP_ARITHMETIC     = 7'b0110011;
  localparam logic [6:0] OP_ARITHMETIC_IMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH         = 7'b1100011;
  localparam logic [6:0] OP_JAL            = 7'b1101111;
  localparam logic [6:0] OP_JALR           = 7'b1100111;
  localparam logic [6:0] OP_LUI            = 7'b0110111;
  localparam logic [6:0] OP_AUIPC          = 7'b0010111;
  localparam logic [6:0] OP_ECALL          = 7'b1110011;

  // ECALL takes its service code from a7
  localparam logic [4:0] REG_X17 = 5'd17;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_stall_unit_hazard_detect.sv
// Combinational hazard detection: load-use against ID/EX and ECALL
// dependences on x17 that forwarding from MEM/WB cannot yet cover.
module hazard_stall_unit_hazard_detect
  import hazard_stall_unit_pkg::*;
(
  input  logic       i_id_valid,
  input  logic [6:0] i_id_opcode,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic [4:0] i_id_ex_rd,
  input  logic       i_id_ex_mem_read,
  input  logic       i_id_ex_write_enable,
  input  logic [4:0] i_ex_mem_rd,
  input  logic       i_ex_mem_mem_read,
  output logic       o_load_use,
  output logic       o_ecall_haz
);

  logic w_is_ecall;
  logic w_use_rs1;
  logic w_use_rs2;
  logic w_rs1_match;
  logic w_rs2_match;

  always_comb begin
    w_is_ecall = (i_id_opcode == OP_ECALL);
    // ECALL's rs fields are not operands; its only dependence is x17
    w_use_rs1  = !(i_id_opcode inside {OP_LUI, OP_AUIPC, OP_JAL}) && !w_is_ecall;
    w_use_rs2  = (i_id_opcode inside {OP_ARITHMETIC, OP_STORE, OP_BRANCH});

    w_rs1_match = w_use_rs1 && (i_id_rs1 == i_id_ex_rd);
    w_rs2_match = w_use_rs2 && (i_id_rs2 == i_id_ex_rd);

    o_load_use  = i_id_valid && i_id_ex_mem_read && (i_id_ex_rd != 5'd0) &&
                  (w_rs1_match || w_rs2_match);

    o_ecall_haz = i_id_valid && w_is_ecall &&
                  ((i_id_ex_write_enable && (i_id_ex_rd == REG_X17)) ||
                   (i_ex_mem_mem_read && (i_ex_mem_rd == REG_X17)));
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall producer for the pipeline: bubbles on hazards, sequences the ECALL
// halt (drain then freeze) and counts hazard-stall cycles.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int          DRAIN_CYCLES = 3,
  parameter int          CNT_W        = 32,
  parameter logic [31:0] HALT_CODE    = 32'd10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             id_ex_write_enable,
  input  logic [4:0]       ex_mem_rd,
  input  logic             ex_mem_mem_read,
  input  logic [31:0]      ecall_x17,
  output logic             is_stall,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             is_halted,
  output logic [CNT_W-1:0] stall_count,
  output state_e           o_dbg_state
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  state_e           r_state;
  state_e           w_next_state;
  logic [DW-1:0]    r_drain_cnt;
  logic [DW-1:0]    w_next_drain_cnt;
  logic             r_is_halted;
  logic [CNT_W-1:0] r_stall_count;

  logic w_load_use;
  logic w_ecall_haz;
  logic w_hazard;
  logic w_halt_req;

  hazard_stall_unit_hazard_detect u_detect (
    .i_id_valid           (id_valid),
    .i_id_opcode          (id_opcode),
    .i_id_rs1             (id_rs1),
    .i_id_rs2             (id_rs2),
    .i_id_ex_rd           (id_ex_rd),
    .i_id_ex_mem_read     (id_ex_mem_read),
    .i_id_ex_write_enable (id_ex_write_enable),
    .i_ex_mem_rd          (ex_mem_rd),
    .i_ex_mem_mem_read    (ex_mem_mem_read),
    .o_load_use           (w_load_use),
    .o_ecall_haz          (w_ecall_haz)
  );

  // A halting ECALL is only recognised once it is hazard-free, so the
  // x17 value it compares is the correctly forwarded one.
  assign w_hazard   = w_load_use || w_ecall_haz;
  assign w_halt_req = !w_hazard && id_valid && (id_opcode == OP_ECALL) &&
                      (ecall_x17 == HALT_CODE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
      r_is_halted <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_drain_cnt <= w_next_drain_cnt;
      r_is_halted <= (w_next_state == ST_HALTED);
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_next_drain_cnt = r_drain_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_halt_req) begin
          w_next_state     = ST_DRAIN;
          w_next_drain_cnt = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == '0) w_next_state = ST_HALTED;
        else                   w_next_drain_cnt = r_drain_cnt - 1'b1;
      end
      ST_HALTED: w_next_state = ST_HALTED;
      default:   w_next_state = ST_RUN;
    endcase
  end

  // While reset is held the outputs obey RUN rules regardless of state.
  always_comb begin
    is_stall    = 1'b0;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if (!reset || (r_state == ST_RUN)) begin
      is_stall    = w_hazard;
      pc_write    = !w_hazard && !w_halt_req;
      if_id_write = !w_hazard && !w_halt_req;
    end else begin
      is_stall    = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_count <= '0;
    end else if ((r_state == ST_RUN) && w_hazard &&
                 (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign is_halted   = r_is_halted;
  assign stall_count = r_stall_count;
  assign o_dbg_state = r_state;

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Producer side of the pipeline's stall interface. It generates `is_stall`, which makes the ID-stage control unit emit a bubble, plus the matching PC and IF/ID write-enables.
- Detects load-use hazards and ECALL x17 dependences.
- Sequences the ECALL halt: drains in-flight instructions, then freezes the pipeline.
- Counts stall cycles for performance reporting.
- Sits beside the control unit, fed from IF/ID, ID/EX and EX/MEM pipeline registers.

Parameters:
- DRAIN_CYCLES, 3, cycles of bubble insertion after a halting ECALL leaves ID (EX, MEM, WB retire).
- CNT_W, 32, width of the stall-cycle counter.
- HALT_CODE, 10, x17 value that makes ECALL halt.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_opcode  in  7  IF/ID inst[6:0]
- id_rs1  in  5  IF/ID inst[19:15]
- id_rs2  in  5  IF/ID inst[24:20]
- id_ex_rd  in  5  ID/EX destination register
- id_ex_mem_read  in  1  ID/EX holds a load
- id_ex_write_enable  in  1  ID/EX writes a register
- ex_mem_rd  in  5  EX/MEM destination register
- ex_mem_mem_read  in  1  EX/MEM holds a load
- ecall_x17  in  32  x17 value as seen by ID after MEM/WB forwarding
- is_stall  out  1  to control unit: zero all control signals (bubble)
- pc_write  out  1  PC register load enable
- if_id_write  out  1  IF/ID register load enable
- is_halted  out  1  pipeline has halted (registered)
- stall_count  out  CNT_W  saturating count of hazard-stall cycles (registered)

Behaviour:
- Operand use, decoded from id_opcode:
  - use_rs1 = not (LUI, AUIPC, JAL).
  - use_rs2 = ARITHMETIC, STORE or BRANCH.
  - ECALL uses x17 only.
- load_use = id_valid & id_ex_mem_read & id_ex_rd≠0 & ((use_rs1 & id_rs1==id_ex_rd) | (use_rs2 & id_rs2==id_ex_rd)).
- ecall_haz = id_valid & opcode==ECALL & ((id_ex_write_enable & id_ex_rd==17) | (ex_mem_mem_read & ex_mem_rd==17)).
- hazard = load_use | ecall_haz. x0 never causes a hazard.
- FSM states: RUN, DRAIN, HALTED. A down-counter drain_cnt holds ceil(log2(DRAIN_CYCLES+1)) bits.
- RUN:
  - is_stall = hazard; pc_write = if_id_write = ~hazard.
  - If ~hazard & id_valid & opcode==ECALL & ecall_x17==HALT_CODE: next state DRAIN, drain_cnt ← DRAIN_CYCLES-1.
  - In that cycle pc_write = if_id_write = 0, and is_stall = 0 so the ECALL itself advances into EX.
- DRAIN:
  - is_stall = 1; pc_write = if_id_write = 0.
  - drain_cnt decrements each cycle; at 0 go to HALTED.
- HALTED: is_stall = 1, pc_write = if_id_write = 0, is_halted = 1. The state is absorbing until reset.
- Output timing:
  - is_halted is registered: it rises in the first HALTED cycle, DRAIN_CYCLES+1 cycles after the ECALL was in ID.
  - is_stall, pc_write and if_id_write are combinational from the state and inputs.
- stall_count:
  - Increments by 1 on each RUN cycle with hazard=1.
  - Saturates at all-ones.
  - Does not count DRAIN or HALTED cycles.
- Simultaneous events:
  - ECALL in ID with ecall_haz: stall first; the halt decision is made only in the first hazard-free cycle, using the then-forwarded ecall_x17.
  - A non-halting ECALL (x17≠HALT_CODE) behaves as a normal instruction.
- Reset (reset==0 at posedge): state ← RUN, drain_cnt ← 0, is_halted ← 0, stall_count ← 0.
  - This applies mid-DRAIN or in HALTED as well.
  - While reset is low, combinational outputs follow RUN rules.
  - id_valid must be 0 from upstream during reset.
- id_valid==0 forces hazard=0 and suppresses halt detection.

Decomposition:
- Shared opcodes include: opcode constants LOAD, STORE, ARITHMETIC, ARITHMETIC_IMM, BRANCH, JAL, JALR, LUI, AUIPC, ECALL.
- Local constants: FSM state encodings and the x17 register index (17). Put them in the opcodes include or a small pipeline-constants include.
- One natural sub-module: hazard_detect (purely combinational load_use/ecall_haz). FSM and counter stay in the top.

Test Plan:
- ID/EX `lw x5`, IF/ID `add x6,x5,x7` -> one cycle with is_stall=1, pc_write=0, if_id_write=0; stall_count 0→1; next cycle (load in EX/MEM) is_stall=0.
- ID/EX `lw x0`, IF/ID `add x1,x0,x0` -> no stall, stall_count unchanged. Also `lw x5` followed by `lui x5` -> no stall (rs unused).
- ID/EX `addi x17,x0,10`, IF/ID ECALL -> is_stall=1 for 1 cycle. Next cycle ecall_x17=10 -> DRAIN; is_halted=1 exactly 4 cycles after the ECALL first hazard-free cycle; pc_write stays 0 thereafter.
- ECALL with ecall_x17=5 -> no DRAIN, is_halted stays 0, pc_write=1.
- Preload 2^CNT_W-1 stall cycles (CNT_W=4 build, 16 load-use stalls) -> stall_count holds 15.
- Assert reset low during DRAIN, then during HALTED -> next cycle state RUN, is_halted=0, stall_count=0, pc_write=1.
